// File: rtl/half_adder_pkg.sv
// Shared definitions for the registered half adder.
// Holds the per-lane result type and the single-lane add function.
package half_adder_pkg;

  localparam int MIN_WIDTH = 1;

  typedef struct packed {
    logic c;
    logic s;
  } ha_res_t;

  function automatic ha_res_t ha_eval(input logic a, input logic b);
    ha_res_t r;
    r.s = a ^ b;
    r.c = a & b;
    return r;
  endfunction

endpackage

// File: rtl/half_adder_ha_cell.sv
// Single-bit combinational half-adder cell.
// Sum and carry of one lane, with no state.
module ha_cell
  import half_adder_pkg::*;
(
  output logic s,
  output logic c,
  input  logic a,
  input  logic b
);

  ha_res_t res;

  always_comb begin
    res = ha_eval(a, b);
    s   = res.s;
    c   = res.c;
  end

endmodule

// File: rtl/half_adder.sv
// Registered multi-lane half adder: WIDTH independent cells feeding
// an output register bank with asynchronous active-low clear.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst_n
);

  if (WIDTH < MIN_WIDTH) begin : g_width_check
    $error("half_adder: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;
  logic [WIDTH-1:0] s_d, s_q;
  logic [WIDTH-1:0] c_d, c_q;

  // Lanes are wired independently so no carry can leak between them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_cell u_cell (
      .s (sum_w[i]),
      .c (carry_w[i]),
      .a (a[i]),
      .b (b[i])
    );
  end

  always_comb begin
    s_d = sum_w;
    c_d = carry_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= '0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s = s_q;
  assign c = c_q;

  a_lane_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (s & c) == '0);

  a_reset_clear: assert property (@(posedge clk)
    !rst_n |-> (s == '0 && c == '0));

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder at WIDTH 1, 4 and 8: vector
// tables, reset sequences and random lanes checked through queues.
module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a1, b1, s1, c1;
  logic [3:0] a4, b4, s4, c4;
  logic [7:0] a8, b8, s8, c8;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]  exp_q[$];
  logic [7:0]  exp4_q[$];
  logic [15:0] exp8_q[$];

  half_adder #(.WIDTH(1)) u_w1 (.s(s1), .c(c1), .a(a1), .b(b1), .clk(clk), .rst_n(rst_n));
  half_adder #(.WIDTH(4)) u_w4 (.s(s4), .c(c4), .a(a4), .b(b4), .clk(clk), .rst_n(rst_n));
  half_adder #(.WIDTH(8)) u_w8 (.s(s8), .c(c8), .a(a8), .b(b8), .clk(clk), .rst_n(rst_n));

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic c;
  } vec1_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic [3:0] c;
  } vec4_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Arithmetic model: {c,s} of each lane is the 2-bit sum a+b.
  function automatic logic [15:0] lane_model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s, c;
    logic [1:0] t;
    for (int i = 0; i < 8; i++) begin
      t = 2'(a[i]) + 2'(b[i]);
      s[i] = t[0];
      c[i] = t[1];
    end
    return {c, s};
  endfunction

  task automatic drive1(input logic a, input logic b);
    @(negedge clk);
    a1 = a;
    b1 = b;
    exp_q.push_back(2'(a) + 2'(b));
  endtask

  task automatic sample1(input string name);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      check(name, {14'b0, c1, s1}, {14'b0, exp_q.pop_front()});
    end
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s, input logic [3:0] c);
    @(negedge clk);
    a4 = a;
    b4 = b;
    exp4_q.push_back({c, s});
  endtask

  task automatic sample4(input string name);
    @(posedge clk);
    #1;
    if (exp4_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      check(name, {8'b0, c4, s4}, {8'b0, exp4_q.pop_front()});
    end
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a8 = a;
    b8 = b;
    exp8_q.push_back(lane_model(a, b));
  endtask

  task automatic sample8(input string name);
    @(posedge clk);
    #1;
    if (exp8_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      check(name, {c8, s8}, exp8_q.pop_front());
    end
    check("w8_onehot", {8'b0, s8 & c8}, 16'h0);
  endtask

  vec1_t tt[4];
  vec4_t v4[5];

  initial begin
    tt[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
    tt[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
    tt[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
    tt[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};
    v4[0] = '{a: 4'b1100, b: 4'b1010, s: 4'b0110, c: 4'b1000};
    v4[1] = '{a: 4'b1111, b: 4'b1111, s: 4'b0000, c: 4'b1111};
    v4[2] = '{a: 4'b1111, b: 4'b0000, s: 4'b1111, c: 4'b0000};
    v4[3] = '{a: 4'b0101, b: 4'b0101, s: 4'b0000, c: 4'b0101};
    v4[4] = '{a: 4'b0011, b: 4'b0110, s: 4'b0101, c: 4'b0010};

    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b0;
    a4 = 4'hf; b4 = 4'h0;
    a8 = 8'hff; b8 = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("reset_w1", {14'b0, c1, s1}, 16'h0);
    check("reset_w4", {8'b0, c4, s4}, 16'h0);
    check("reset_w8", {c8, s8}, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_w1", {14'b0, c1, s1}, 16'h0);
    check("reset_hold_w8", {c8, s8}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Truth table, one cycle latency per entry.
    for (int i = 0; i < 4; i++) begin
      drive1(tt[i].a, tt[i].b);
      sample1($sformatf("truth_%0d", i));
      check($sformatf("truth_tbl_%0d", i), {14'b0, c1, s1}, {14'b0, tt[i].c, tt[i].s});
    end

    // Asynchronous reset between edges.
    drive1(1'b1, 1'b0);
    sample1("async_pre");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", {14'b0, c1, s1}, 16'h0);
    @(posedge clk);
    #1;
    check("async_hold", {14'b0, c1, s1}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("async_release", {14'b0, c1, s1}, 16'h1);

    // Reset mid-stream while inputs change.
    drive1(1'b1, 1'b1);
    sample1("mid_pre");
    @(negedge clk);
    rst_n = 1'b0;
    a1 = 1'b0;
    b1 = 1'b1;
    #1;
    check("mid_clear", {14'b0, c1, s1}, 16'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("mid_hold_%0d", i), {14'b0, c1, s1}, 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_release", {14'b0, c1, s1}, 16'h1);

    // Latency: s follows a by one cycle with b held low.
    for (int i = 0; i < 8; i++) begin
      drive1(1'(i % 2), 1'b0);
      sample1($sformatf("latency_%0d", i));
    end

    // Four-lane vectors, no cross-lane carry.
    for (int i = 0; i < 5; i++) begin
      drive4(v4[i].a, v4[i].b, v4[i].s, v4[i].c);
      sample4($sformatf("w4_vec_%0d", i));
    end

    // Random eight-lane pairs.
    for (int i = 0; i < 1000; i++) begin
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      sample8($sformatf("w8_rand_%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
